// File: rtl/regfile32x32.sv
// regfile32x32: 32x32 CPU register file with one-hot write decode, two
// combinational read ports and a valid/ready register dump sequencer.
// Optional build macro: REGFILE_BYPASS_EN enables same-cycle write-to-read
// forwarding on both read ports (the dump path is never forwarded).
module regfile32x32 #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int unsigned        NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(NREG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SHOW = 2'd2,
    DONE = 2'd3
  } state_e;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [NREG-1:0]   wr_dec;
  logic [DATA_W-1:0] stored_a;
  logic [DATA_W-1:0] stored_b;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  // One-hot write decode gated by wr_en; register 0 is never enabled
  always_comb begin
    wr_dec = '0;
    if (wr_en) begin
      wr_dec = NREG'(1) << wr_addr;
    end
    wr_dec[0] = 1'b0;
  end

  // Register storage; entry 0 keeps its reset value of zero forever
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[ADDR_W'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NREG; i++) begin
        if (wr_dec[ADDR_W'(i)]) begin
          regs_q[ADDR_W'(i)] <= wr_data;
        end
      end
    end
  end

  // Combinational read muxes, optionally forwarding the in-flight write
  always_comb begin
    stored_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    stored_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    rd_data_a = (wr_en && (wr_addr == rd_addr_a) && (wr_addr != '0)) ? wr_data : stored_a;
    rd_data_b = (wr_en && (wr_addr == rd_addr_b) && (wr_addr != '0)) ? wr_data : stored_b;
`else
    rd_data_a = stored_a;
    rd_data_b = stored_b;
`endif
  end

  // Dump sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Dump next-state: LOAD snapshots reg[ptr] (pre-write), SHOW holds until accepted
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dump_start) begin
          ptr_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = regs_q[ptr_q];
        state_d = SHOW;
      end
      SHOW: begin
        if (dump_ready) begin
          if (ptr_q == LAST) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == SHOW);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  assign dump_valid = valid_q;
  assign dump_busy  = busy_q;
  assign dump_done  = done_q;
  assign dump_addr  = ptr_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_regfile32x32.sv
// Self-checking bench for regfile32x32: a behavioural register/dump model
// checked every cycle, plus directed vectors with literal expectations.
module tb_regfile32x32;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [31:0] rd_data_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_b;
  logic        dump_start;
  logic        dump_valid;
  logic        dump_ready;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_busy;
  logic        dump_done;

  regfile32x32 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr_a  (rd_addr_a),
    .rd_data_a  (rd_data_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_b  (rd_data_b),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: register contents plus the dump as a sequence of beats
  logic [31:0] mdl [32];
  logic        m_busy, m_load, m_valid, m_done;
  logic [4:0]  m_beat;
  logic [31:0] m_snap;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] <= '0;
      m_busy  <= 1'b0;
      m_load  <= 1'b0;
      m_valid <= 1'b0;
      m_done  <= 1'b0;
      m_beat  <= '0;
      m_snap  <= '0;
    end else begin
      if (m_done) begin
        m_done <= 1'b0;
        m_busy <= 1'b0;
      end else if (!m_busy) begin
        if (dump_start) begin
          m_busy <= 1'b1;
          m_load <= 1'b1;
          m_beat <= '0;
        end
      end else if (m_load) begin
        m_snap  <= mdl[m_beat];
        m_load  <= 1'b0;
        m_valid <= 1'b1;
      end else if (dump_ready) begin
        m_valid <= 1'b0;
        if (m_beat == 5'd31) m_done <= 1'b1;
        else begin
          m_beat <= m_beat + 5'd1;
          m_load <= 1'b1;
        end
      end
      if (wr_en && wr_addr != 5'd0) mdl[wr_addr] <= wr_data;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr == a) return wr_data;
`endif
    return mdl[a];
  endfunction

  int          n_vec = 0;
  int          n_err = 0;
  int          n_beats = 0;
  int          n_done = 0;
  int          n_busy = 0;
  logic [31:0] beat_data [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One cycle: compare everything against the model on the falling edge
  task automatic tick();
    @(negedge clk);
    chk("model_rd_a", rd_data_a, exp_rd(rd_addr_a));
    chk("model_rd_b", rd_data_b, exp_rd(rd_addr_b));
    chk("model_valid", 32'(dump_valid), 32'(m_valid));
    chk("model_busy", 32'(dump_busy), 32'(m_busy));
    chk("model_done", 32'(dump_done), 32'(m_done));
    if (m_valid) begin
      chk("model_addr", 32'(dump_addr), 32'(m_beat));
      chk("model_data", dump_data, m_snap);
    end
    if (!rst_n) begin
      chk("rst_addr", 32'(dump_addr), 32'h0);
      chk("rst_data", dump_data, 32'h0);
    end
    if (dump_valid && dump_ready) begin
      beat_data[dump_addr] = dump_data;
      n_beats++;
    end
    if (dump_done) n_done++;
    if (dump_busy) n_busy++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 8 && !dump_valid; k++) tick();
    chk(nm, 32'(dump_valid), 32'd1);
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && dump_busy; k++) tick();
    chk(nm, 32'(dump_busy), 32'd0);
  endtask

  int b0, d0, s0;

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; dump_start = 1'b0; dump_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_busy", 32'(dump_busy), 32'd0);
    chk("rst_done", 32'(dump_done), 32'd0);
    rst_n = 1'b1;
    tick();

    // All registers read zero after reset
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i); rd_addr_b = 5'(31 - i);
      #1;
      chk("rst_rd_a", rd_data_a, 32'h0);
      chk("rst_rd_b", rd_data_b, 32'h0);
      tick();
    end

    // Write then read, and register 0 discards writes
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #1;
    chk("wr5_rd_a", rd_data_a, 32'hDEADBEEF);
    chk("wr5_rd_b", rd_data_b, 32'hDEADBEEF);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    tick();
    wr_en = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    #1;
    chk("r0_rd_a", rd_data_a, 32'h0);
    chk("r0_rd_b", rd_data_b, 32'h0);

    // Same-cycle write/read of register 7
    rd_addr_a = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("fwd_same_cycle", rd_data_a, 32'hA5A5A5A5);
`else
    chk("fwd_same_cycle", rd_data_a, 32'h0);
`endif
    tick();
    wr_en = 1'b0;
    #1;
    chk("fwd_after_edge", rd_data_a, 32'hA5A5A5A5);

    // Preload reg N = 0x100+N (reg 0 write is discarded)
    for (int n = 0; n < 32; n++) begin
      wr_en = 1'b1; wr_addr = 5'(n); wr_data = 32'h100 + 32'(n);
      tick();
    end
    wr_en = 1'b0;

    // Full dump with ready held high; a start during DONE is ignored
    for (int i = 0; i < 32; i++) beat_data[i] = 'x;
    b0 = n_beats; d0 = n_done; s0 = n_busy;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 200 && dump_busy; k++) begin
      dump_start = dump_done;
      tick();
    end
    dump_start = 1'b0;
    chk("full_drain", 32'(dump_busy), 32'd0);
    chk("full_beats", 32'(n_beats - b0), 32'd32);
    chk("full_done_once", 32'(n_done - d0), 32'd1);
    chk("full_cycles", 32'(n_busy - s0), 32'd65);
    for (int i = 0; i < 32; i++)
      chk("full_beat_data", beat_data[i], (i == 0) ? 32'h0 : 32'h100 + 32'(i));
    tick(); tick();
    chk("start_in_done_ignored", 32'(dump_busy), 32'd0);

    // Backpressure on beat 3 with a write to reg 3; write to reg 5 during its LOAD
    dump_ready = 1'b0; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int bt = 0; bt < 32; bt++) begin
      wait_valid("bp_wait_valid");
      wr_en = 1'b0;
      chk("bp_beat_addr", 32'(dump_addr), 32'(bt));
      if (bt == 3) begin
        for (int s = 0; s < 5; s++) begin
          wr_en = (s == 1); wr_addr = 5'd3; wr_data = 32'hCAFEF00D;
          #1;
          chk("stall_valid", 32'(dump_valid), 32'd1);
          chk("stall_addr", 32'(dump_addr), 32'd3);
          chk("stall_data", dump_data, 32'h103);
          tick();
        end
        wr_en = 1'b0;
      end
      if (bt == 5) chk("load_prewrite", dump_data, 32'h105);
      dump_ready = 1'b1;
      tick();
      dump_ready = 1'b0;
      if (bt == 4) begin
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h55555555;
      end
    end
    wr_en = 1'b0;
    drain("bp_drain");
    rd_addr_a = 5'd3; rd_addr_b = 5'd5;
    #1;
    chk("bp_reg3", rd_data_a, 32'hCAFEF00D);
    chk("bp_reg5", rd_data_b, 32'h55555555);

    // Reset in the middle of the dump at beat 10, then restart from 0
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 0; k < 100 && !(dump_valid && dump_addr == 5'd10); k++) tick();
    chk("reach_beat10", 32'(dump_addr), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(dump_valid), 32'd0);
    chk("midrst_busy", 32'(dump_busy), 32'd0);
    chk("midrst_addr", 32'(dump_addr), 32'd0);
    chk("midrst_data", dump_data, 32'h0);
    tick();
    rst_n = 1'b1; dump_ready = 1'b0; rd_addr_a = 5'd3;
    #1;
    chk("midrst_reg3", rd_data_a, 32'h0);
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    wait_valid("restart_valid");
    chk("restart_addr", 32'(dump_addr), 32'd0);
    chk("restart_data", dump_data, 32'h0);
    dump_ready = 1'b1;
    drain("restart_drain");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile32x32.md
# regfile32x32

32-entry by 32-bit general-purpose register file for the single-cycle CPU. It is the consumer of the 5-bit write-register select produced by the destination-register mux: a 5-to-32 write decoder turns that select into one write enable per register. It also provides two combinational read ports for the rs/rt operands. A debug dump sequencer walks all registers out over a valid/ready handshake, for bench checking and board-level readout.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; entry count is 2**ADDR_W. Only ADDR_W=5 is supported.

- clk  in  1  rising-edge clock for all state.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe (RegWrite).
- wr_addr  in  5  destination register, driven by the 5-bit destination mux.
- wr_data  in  32  write-back data.
- rd_addr_a  in  5  read port A address (rs).
- rd_data_a  out  32  read port A data.
- rd_addr_b  in  5  read port B address (rt).
- rd_data_b  out  32  read port B data.
- dump_start  in  1  single-cycle request to start a full register dump.
- dump_valid  out  1  dump beat valid.
- dump_ready  in  1  dump beat accepted.
- dump_addr  out  5  register index of the current beat.
- dump_data  out  32  register value of the current beat.
- dump_busy  out  1  high from dump start until the cycle after the last beat is accepted.
- dump_done  out  1  one-cycle pulse after beat 31 is accepted.

## Operation
- **Write decoder:** wr_addr is decoded one-hot into 32 enables, gated by wr_en.
  - Register N is written with wr_data on the clk edge when wr_en=1 and wr_addr=N.
- **Register 0:** hardwired to zero.
  - Writes to register 0 are discarded.
  - Reads of register 0, on any port, return 0.
- **Read ports:** combinational mux of the stored registers. Both ports may address the same register.
- **Reset:** all registers clear to 0. Outputs take these values:
  - dump_valid=0, dump_busy=0, dump_done=0, dump_addr=0, dump_data=0.
- **Dump FSM states:** IDLE, LOAD, SHOW, DONE.
  - IDLE: dump_start=1 sets ptr=0 and moves to LOAD. dump_start is ignored in every other state.
  - LOAD: dump_data is loaded with reg[ptr]; the FSM moves to SHOW. dump_valid=0.
  - SHOW: dump_valid=1, dump_addr=ptr, dump_data held stable.
    - On dump_ready=1 with ptr=31: move to DONE.
    - On dump_ready=1 with ptr<31: ptr increments and the FSM returns to LOAD.
    - With dump_ready=0: the FSM stays in SHOW.
  - DONE: dump_done=1 for one cycle; the FSM returns to IDLE.
  - dump_busy=1 in LOAD, SHOW and DONE.
- **Dump and normal writes:** the dump never stalls or blocks CPU writes.
  - If a write to reg[ptr] occurs in the LOAD cycle, the captured value is the pre-write value.
  - Writes to a register after its beat has been loaded do not alter dump_data.

## Timing
- Write latency: 1 edge. The stored value is visible on the read ports combinationally after that edge.
- Read latency: 0 cycles (combinational from rd_addr_*).
- Dump throughput: one beat every 2 cycles with dump_ready held high.
- Full dump: 64 cycles from the edge that samples dump_start to the edge that leaves SHOW, plus 1 DONE cycle.
- The handshake completes on an edge where dump_valid and dump_ready are both 1. dump_valid never drops without acceptance.
- rst_n asserted mid-dump: the FSM goes immediately to IDLE and all outputs return to their reset values. The registers also clear.
- dump_start in the same cycle as DONE is ignored. A new dump must be requested from IDLE.

## Configuration
- REGFILE_BYPASS_EN defined: write-to-read forwarding is enabled.
  - Condition: wr_en=1, wr_addr equals rd_addr_x, and wr_addr≠0.
  - Effect: rd_data_x returns wr_data in the same cycle.
  - The dump path is not bypassed.
- REGFILE_BYPASS_EN undefined: read ports return stored values only. The new data appears after the write edge.

## Test plan
- **Reset clears registers:** assert rst_n=0 then release; read registers 0..31 on both ports -> all return 0x00000000.
- **Write then read:** write 0xDEADBEEF to register 5; read register 5 on ports A and B the next cycle -> 0xDEADBEEF on both. Write 0x12345678 to register 0 -> register 0 still reads 0.
- **Same-cycle forwarding:** wr_en=1, wr_addr=7, wr_data=0xA5A5A5A5, rd_addr_a=7 in the same cycle.
  - With REGFILE_BYPASS_EN: rd_data_a=0xA5A5A5A5 in that cycle.
  - Without it: rd_data_a shows the old value, then 0xA5A5A5A5 after the edge.
- **Full dump:** preload register N with 0x100+N; pulse dump_start with dump_ready=1 -> 32 beats with addr 0..31 and data 0 followed by 0x101..0x11F. dump_done pulses exactly once; the full sequence takes 65 cycles.
- **Backpressure:** hold dump_ready=0 for 5 cycles during beat 3 -> dump_valid, dump_addr=3 and dump_data stay stable. Writing register 3 during the stall does not change dump_data.
- **Reset mid-dump:** pulse rst_n low at beat 10 -> dump_valid and dump_busy drop to 0 immediately; a new dump_start restarts from address 0.
